// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI frame slave.
// The frame layout is operation code first, then num2, then num1, all MSB-first.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned OPA_W_DEF  = 4;
    localparam int unsigned OPB_W_DEF  = 4;
    localparam int unsigned OP_W_DEF   = 2;
    localparam int unsigned RESP_W_DEF = 8;
    localparam int unsigned FCNT_W     = 8;

endpackage

// File: rtl/spi_shift_reg.sv
// Serial-in / parallel-out left shifter with synchronous parallel load.
// Shifts or loads only on clock edges where en is high.
module spi_shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            if (load) begin
                q <= load_val;
            end else begin
                q <= {q[W-2:0], din};
            end
        end
    end

endmodule

// File: rtl/spi_frame_slave.sv
// SPI slave clocked by sclk: receives an op/num2/num1 frame, returns a response on MISO,
// and publishes the decoded fields only when a whole frame has been received.
module spi_frame_slave
    import spi_pkg::*;
#(
    parameter int unsigned OPA_W  = OPA_W_DEF,
    parameter int unsigned OPB_W  = OPB_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF,
    parameter int unsigned RESP_W = RESP_W_DEF
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              SS,
    input  logic              MOSI,
    input  logic [RESP_W-1:0] resp_data,
    output logic              MISO,
    output logic [OPA_W-1:0]  num1,
    output logic [OPB_W-1:0]  num2,
    output logic [OP_W-1:0]   operacion,
    output logic              frame_valid,
    output logic              frame_err,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy
);

    localparam int unsigned FRAME_W = OPA_W + OPB_W + OP_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [FRAME_W-1:0]   rx_q;
    logic [FRAME_W-1:0]   resp_q;
    logic [FRAME_W-1:0]   resp_load;
    logic [FRAME_W-1:0]   frame_word;
    logic                 unused_bits;

    // Response word left-aligned into the frame: pad LSBs or keep only the top bits
    generate
        if (RESP_W >= FRAME_W) begin : g_resp_trunc
            logic unused_resp;
            assign resp_load = resp_data[RESP_W-1 -: FRAME_W];
            if (RESP_W > FRAME_W) begin : g_resp_drop
                assign unused_resp = &{1'b0, resp_data[RESP_W-FRAME_W-1:0]};
            end else begin : g_resp_exact
                assign unused_resp = 1'b0;
            end
        end else begin : g_resp_pad
            assign resp_load = {resp_data, (FRAME_W-RESP_W)'(0)};
        end
    endgenerate

    spi_shift_reg #(.W(FRAME_W)) u_rx_sr (
        .clk      (sclk),
        .rst      (rst),
        .en       (SS),
        .load     (1'b0),
        .load_val ('0),
        .din      (MOSI),
        .q        (rx_q)
    );

    spi_shift_reg #(.W(FRAME_W)) u_resp_sr (
        .clk      (sclk),
        .rst      (rst),
        .en       (SS),
        .load     (state == IDLE),
        .load_val (resp_load),
        .din      (1'b0),
        .q        (resp_q)
    );

    // The completing bit arrives on MOSI during the final edge, so decode from the next value
    assign frame_word  = {rx_q[FRAME_W-2:0], MOSI};
    assign MISO        = SS & resp_q[FRAME_W-1];
    assign unused_bits = &{1'b0, rx_q[FRAME_W-1], resp_q[FRAME_W-2:0]};

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            num1        <= '0;
            num2        <= '0;
            operacion   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (SS) begin
                if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                    operacion   <= frame_word[FRAME_W-1 -: OP_W];
                    num2        <= frame_word[OPA_W+OPB_W-1 -: OPB_W];
                    num1        <= frame_word[OPA_W-1:0];
                    frame_valid <= 1'b1;
                    frame_cnt   <= frame_cnt + FCNT_W'(1);
                    frame_err   <= 1'b0;
                    bit_cnt     <= '0;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    state   <= SHIFT;
                    busy    <= 1'b1;
                end
            end else if (state == SHIFT) begin
                // SS dropped mid-frame: drop the partial frame, keep published outputs
                bit_cnt   <= '0;
                state     <= IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave with default widths (10-bit frames, 8-bit response).
// Drives SS/MOSI on the falling edge and samples 1 ns after each rising edge.
module tb_spi_frame_slave;

    logic       sclk;
    logic       rst;
    logic       SS;
    logic       MOSI;
    logic [7:0] resp_data;
    logic       MISO;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [1:0] operacion;
    logic       frame_valid;
    logic       frame_err;
    logic [7:0] frame_cnt;
    logic       busy;

    logic [1:0] exp_op;
    logic [3:0] exp_n2;
    logic [3:0] exp_n1;
    logic [7:0] exp_cnt;
    logic       exp_err;
    int         checks;
    int         errors;
    int         valid_seen;

    spi_frame_slave dut (
        .sclk        (sclk),
        .rst         (rst),
        .SS          (SS),
        .MOSI        (MOSI),
        .resp_data   (resp_data),
        .MISO        (MISO),
        .num1        (num1),
        .num2        (num2),
        .operacion   (operacion),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".op"},   32'(operacion), 32'(exp_op));
        check({tag, ".num2"}, 32'(num2),      32'(exp_n2));
        check({tag, ".num1"}, 32'(num1),      32'(exp_n1));
        check({tag, ".cnt"},  32'(frame_cnt), 32'(exp_cnt));
        check({tag, ".err"},  32'(frame_err), 32'(exp_err));
    endtask

    task automatic edge_with(input logic ss, input logic mosi);
        @(negedge sclk);
        SS   = ss;
        MOSI = mosi;
        @(posedge sclk);
        #1;
    endtask

    // Full frame with SS high on every edge; MISO compared against miso_exp MSB-first
    task automatic send_frame(input logic [9:0] f, input logic [9:0] miso_exp);
        for (int k = 1; k <= 10; k++) begin
            edge_with(1'b1, f[10-k]);
            check("miso", 32'(MISO), 32'(miso_exp[10-k]));
            if (frame_valid === 1'b1) valid_seen++;
            if (k < 10) begin
                check("busy_mid", 32'(busy), 32'd1);
                check("valid_mid", 32'(frame_valid), 32'd0);
                check("op_hold", 32'(operacion), 32'(exp_op));
                check("num1_hold", 32'(num1), 32'(exp_n1));
            end else begin
                exp_op  = f[9:8];
                exp_n2  = f[7:4];
                exp_n1  = f[3:0];
                exp_cnt = exp_cnt + 8'd1;
                exp_err = 1'b0;
                check("valid_end", 32'(frame_valid), 32'd1);
                check("busy_end", 32'(busy), 32'd0);
                check_outputs("frame_end");
            end
        end
    endtask

    task automatic send_bits(input logic [9:0] f, input int n);
        for (int k = 1; k <= n; k++) begin
            edge_with(1'b1, f[10-k]);
            check("busy_part", 32'(busy), 32'd1);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        valid_seen = 0;
        exp_op     = '0;
        exp_n2     = '0;
        exp_n1     = '0;
        exp_cnt    = '0;
        exp_err    = 1'b0;
        rst        = 1'b1;
        SS         = 1'b0;
        MOSI       = 1'b0;
        resp_data  = 8'h00;

        // Reset state
        @(posedge sclk);
        @(posedge sclk);
        #1;
        check_outputs("reset");
        check("reset.valid", 32'(frame_valid), 32'd0);
        check("reset.busy",  32'(busy),        32'd0);
        check("reset.miso",  32'(MISO),        32'd0);
        @(negedge sclk);
        rst = 1'b0;

        // Nominal frame 1,0,0,1,0,1,1,0,0,1 with response A5
        resp_data = 8'hA5;
        send_frame(10'b1001011001, 10'b1010010100);
        check("nom.op",   32'(operacion), 32'h2);
        check("nom.num2", 32'(num2),      32'h5);
        check("nom.num1", 32'(num1),      32'h9);
        check("nom.cnt",  32'(frame_cnt), 32'd1);
        edge_with(1'b0, 1'b0);
        check("nom.valid_clear", 32'(frame_valid), 32'd0);
        check("nom.miso_ss0",    32'(MISO),        32'd0);
        check_outputs("nom.idle");

        // Abort after 4 bits
        send_bits(10'b1111111111, 4);
        check("abort.op_hold", 32'(operacion), 32'h2);
        edge_with(1'b0, 1'b1);
        exp_err = 1'b1;
        check("abort.err",  32'(frame_err), 32'd1);
        check("abort.busy", 32'(busy),      32'd0);
        check("abort.miso", 32'(MISO),      32'd0);
        check_outputs("abort");
        edge_with(1'b0, 1'b0);
        check("abort.err_sticky", 32'(frame_err), 32'd1);
        send_frame(10'b0110100011, 10'b1010010100);
        check("recover.op",   32'(operacion), 32'h1);
        check("recover.num2", 32'(num2),      32'hA);
        check("recover.num1", 32'(num1),      32'h3);
        check("recover.err",  32'(frame_err), 32'd0);
        check("recover.cnt",  32'(frame_cnt), 32'd2);

        // Back-to-back frames, no gap edge
        resp_data = 8'hFF;
        send_frame(10'h3FF, 10'b1111111100);
        check("b2b1.op",   32'(operacion), 32'h3);
        check("b2b1.num2", 32'(num2),      32'hF);
        check("b2b1.num1", 32'(num1),      32'hF);
        send_frame(10'h000, 10'b1111111100);
        check("b2b2.op",   32'(operacion), 32'h0);
        check("b2b2.num2", 32'(num2),      32'h0);
        check("b2b2.num1", 32'(num1),      32'h0);
        check("b2b2.cnt",  32'(frame_cnt), 32'd4);

        // Async reset between edge 5 and 6
        resp_data = 8'h3C;
        send_frame(10'b1110001110, 10'b0011110000);
        send_bits(10'b1010101010, 5);
        rst = 1'b1;
        #2;
        exp_op  = '0;
        exp_n2  = '0;
        exp_n1  = '0;
        exp_cnt = '0;
        exp_err = 1'b0;
        check_outputs("arst");
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.miso", 32'(MISO), 32'd0);
        rst = 1'b0;
        send_frame(10'b1100110101, 10'b0011110000);
        check("arst_next.op",   32'(operacion), 32'h3);
        check("arst_next.num2", 32'(num2),      32'h3);
        check("arst_next.num1", 32'(num1),      32'h5);
        check("arst_next.cnt",  32'(frame_cnt), 32'd1);

        // Counter wrap: 256 frames from a fresh reset
        edge_with(1'b0, 1'b0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        exp_op     = '0;
        exp_n2     = '0;
        exp_n1     = '0;
        exp_cnt    = '0;
        exp_err    = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 256; i++) begin
            resp_data = 8'($urandom);
            send_frame(10'($urandom), {resp_data, 2'b00});
        end
        check("wrap.cnt",    32'(frame_cnt), 32'd0);
        check("wrap.pulses", 32'(valid_seen), 32'd256);
        edge_with(1'b0, 1'b0);
        check("wrap.valid_clear", 32'(frame_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
